// File: rtl/rs_pkg.sv
// Shared GF(8) definitions for the RS(7,5) encoder and decoder-side GF code.
// No logic latency: constants, the state enum and a combinational GF multiply.
// No flow control; gf_mul is pure combinational.
// Contents: SYM_W/N/K geometry, PRIM_POLY, generator coefficients G1/G0,
//           state_t {IDLE, SHIFT, OUT}, gf_mul(a, b).
package rs_pkg;

    localparam int SYM_W = 3;
    localparam int N     = 7;
    localparam int K     = 5;
    localparam int MSG_W = SYM_W * K;
    localparam int PAR_W = SYM_W * (N - K);
    localparam int CW_W  = SYM_W * N;

    localparam logic [3:0]       PRIM_POLY = 4'b1011;
    // g(x) = (x + a)(x + a^2) = x^2 + 6x + 3
    localparam logic [SYM_W-1:0] G1 = 3'd6;
    localparam logic [SYM_W-1:0] G0 = 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } state_t;

    // Shift-and-add multiply; each doubling of the running operand is
    // reduced by the primitive polynomial as soon as it overflows x^2.
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] acc;
        logic [SYM_W-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[SYM_W-2:0], 1'b0} ^ (sh[SYM_W-1] ? PRIM_POLY[SYM_W-1:0] : {SYM_W{1'b0}});
        end
        return acc;
    endfunction

endpackage

// File: rtl/rs_parity_lfsr.sv
// Parity LFSR dividing the shifted-in message by g(x) = x^2 + 6x + 3.
// One symbol per shift_en cycle; parity reflects all symbols shifted so far.
// No backpressure: the caller sequences clr/shift_en.
// Ports: clk, reset (sync, high), clr (zero LFSR), shift_en, sym_in[2:0],
//        parity[5:0] = {r1, r0}.
module rs_parity_lfsr
    import rs_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               shift_en,
    input  logic [SYM_W-1:0]   sym_in,
    output logic [PAR_W-1:0]   parity
);

    logic [SYM_W-1:0] r_r1;
    logic [SYM_W-1:0] r_r0;
    logic [SYM_W-1:0] w_fb;

    assign w_fb = sym_in ^ r_r1;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_r1 <= '0;
            r_r0 <= '0;
        end else if (shift_en) begin
            r_r1 <= r_r0 ^ gf_mul(w_fb, G1);
            r_r0 <= gf_mul(w_fb, G0);
        end
    end

    assign parity = {r_r1, r_r0};

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(7,5) encoder over GF(8): 5 message symbols in, 21-bit codeword out.
// Latency: codeword valid 6 cycles after acceptance; one codeword per >= 7 cycles.
// Backpressure: codeword/cw_valid held until cw_ready; msg_ready only in IDLE.
// Ports: clk, reset (sync, high), msg_valid/msg[14:0]/msg_ready in,
//        cw_valid/codeword[20:0]/cw_ready out.
// Option RS_ERR_INJECT_EN: adds err_pos[2:0]/err_val[2:0], latched at acceptance,
//        XORing err_val into symbol err_pos (1 = bits[2:0]) of the output codeword.
module rs_encoder
    import rs_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               msg_valid,
    input  logic [MSG_W-1:0]   msg,
    output logic               msg_ready,
    output logic               cw_valid,
    output logic [CW_W-1:0]    codeword,
    input  logic               cw_ready
`ifdef RS_ERR_INJECT_EN
    ,
    input  logic [SYM_W-1:0]   err_pos,
    input  logic [SYM_W-1:0]   err_val
`endif
);

    state_t             r_state;
    state_t             w_next_state;
    logic [2:0]         r_cnt;
    logic [MSG_W-1:0]   r_shift;
    logic [MSG_W-1:0]   r_msg;
    logic [PAR_W-1:0]   w_parity;
    logic [CW_W-1:0]    w_cw_mask;
    logic               w_accept;
    logic               w_shift_en;
    logic [SYM_W-1:0]   w_sym;

    assign w_accept   = msg_valid && (r_state == IDLE);
    assign w_shift_en = (r_state == SHIFT);
    // Highest symbol (m4) leaves the shift register first.
    assign w_sym      = r_shift[MSG_W-1 -: SYM_W];

    always_comb begin
        w_next_state = r_state;
        msg_ready    = 1'b0;
        cw_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == 3'(K - 1)) begin
                    w_next_state = OUT;
                end
            end
            OUT: begin
                cw_valid = 1'b1;
                if (cw_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_msg   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt   <= '0;
                r_shift <= msg;
                r_msg   <= msg;
            end else if (w_shift_en) begin
                r_cnt   <= r_cnt + 3'd1;
                r_shift <= {r_shift[MSG_W-SYM_W-1:0], {SYM_W{1'b0}}};
            end
        end
    end

    rs_parity_lfsr u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_accept),
        .shift_en (w_shift_en),
        .sym_in   (w_sym),
        .parity   (w_parity)
    );

`ifdef RS_ERR_INJECT_EN
    logic [CW_W-1:0] r_err_mask;
    logic [CW_W-1:0] w_err_mask;

    // Position p (1..7) addresses bits[3p-1 -: 3]; position 0 matches nothing.
    always_comb begin
        w_err_mask = '0;
        for (int p = 1; p <= N; p++) begin
            if (err_pos == 3'(p)) begin
                w_err_mask[SYM_W*p-1 -: SYM_W] = err_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_mask <= '0;
        end else if (w_accept) begin
            r_err_mask <= w_err_mask;
        end
    end

    assign w_cw_mask = r_err_mask;
`else
    assign w_cw_mask = '0;
`endif

    // Parity regs stop shifting in OUT, so the codeword is stable while held.
    assign codeword = {r_msg, w_parity} ^ w_cw_mask;

endmodule

// File: tb/tb_rs_encoder.sv
module tb_rs_encoder;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        msg_valid = 1'b0;
    logic [14:0] msg       = '0;
    logic        cw_ready  = 1'b1;
    logic        msg_ready;
    logic        cw_valid;
    logic [20:0] codeword;
`ifdef RS_ERR_INJECT_EN
    logic [2:0]  err_pos = '0;
    logic [2:0]  err_val = '0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rs_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .msg_valid (msg_valid),
        .msg       (msg),
        .msg_ready (msg_ready),
        .cw_valid  (cw_valid),
        .codeword  (codeword),
        .cw_ready  (cw_ready)
`ifdef RS_ERR_INJECT_EN
        ,
        .err_pos   (err_pos),
        .err_val   (err_val)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: GF(8) arithmetic from first principles, and the parity
    // chosen as the unique pair making the codeword vanish at a and a^2.
    function automatic int gmul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 3; i++) begin
            if (((b >> i) & 1) != 0) p = p ^ (a << i);
        end
        for (int bt = 4; bt >= 3; bt--) begin
            if (((p >> bt) & 1) != 0) p = p ^ (11 << (bt - 3));
        end
        return p & 7;
    endfunction

    function automatic int eval_cw(input logic [20:0] cw, input int x);
        int acc;
        acc = 0;
        for (int i = 6; i >= 0; i--) begin
            acc = gmul(acc, x) ^ int'(cw[3*i +: 3]);
        end
        return acc;
    endfunction

    function automatic logic [20:0] ref_cw(input logic [14:0] m);
        logic [20:0] cand;
        logic [5:0]  par;
        ref_cw = '0;
        for (int p = 0; p < 64; p++) begin
            par  = 6'(p);
            cand = {m, par};
            if (eval_cw(cand, 2) == 0 && eval_cw(cand, 4) == 0) ref_cw = cand;
        end
    endfunction

`ifdef RS_ERR_INJECT_EN
    function automatic logic [20:0] err_mask(input int pos, input int val);
        logic [20:0] mk;
        mk = '0;
        if (pos != 0) mk = 21'(val) << (3 * (pos - 1));
        return mk;
    endfunction
`endif

    task automatic tick();
        @(negedge clk);
    endtask

    // Present m at a negedge when msg_ready; returns at the first negedge after acceptance.
    task automatic accept(input logic [14:0] m);
        int n;
        n = 0;
        while (msg_ready !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) check("accept_timeout", 0, 1);
        msg_valid = 1'b1;
        msg       = m;
        tick();
        msg_valid = 1'b0;
        msg       = 15'($urandom);
    endtask

    task automatic wait_valid(inout int lat);
        while (cw_valid !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        if (lat >= 30) check("cw_valid_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        logic [20:0] exp_cw;
        logic [14:0] m;
        int hold;

        // Reset state
        tick();
        tick();
        check("rst_cw_valid", 32'(cw_valid), 0);
        check("rst_msg_ready", 32'(msg_ready), 1);
        check("rst_codeword", 32'(codeword), 0);
        reset = 1'b0;
        tick();

        // All-zero message and latency
        cw_ready = 1'b1;
        accept(15'h0000);
        lat = 1;
        wait_valid(lat);
        check("t1_latency", 32'(lat), 6);
        check("t1_codeword", 32'(codeword), 32'h000000);
        tick();
        check("t1_cw_valid_drop", 32'(cw_valid), 0);
        check("t1_msg_ready", 32'(msg_ready), 1);

        // m0 = 1
        accept(15'h0001);
        lat = 1;
        wait_valid(lat);
        check("t2_codeword", 32'(codeword), 32'h000073);
        tick();

        // m4 = 1 with mid-LFSR observation after two symbols
        accept(15'h1000);
        tick();
        tick();
        check("t3_mid_lfsr", 32'(dut.w_parity), 32'h09);
        lat = 3;
        wait_valid(lat);
        check("t3_latency", 32'(lat), 6);
        check("t3_codeword", 32'(codeword), 32'h040032);
        tick();

        // Backpressure: hold in OUT, extra messages ignored
        cw_ready = 1'b0;
        m = 15'h2A5B;
        exp_cw = ref_cw(m);
        accept(m);
        lat = 1;
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_codeword", 32'(codeword), 32'(exp_cw));
            check("t4_hold_valid", 32'(cw_valid), 1);
            check("t4_hold_msg_ready", 32'(msg_ready), 0);
            msg_valid = (i % 2 == 0);
            msg = 15'($urandom);
            tick();
        end
        msg_valid = 1'b0;
        check("t4_before_release", 32'(codeword), 32'(exp_cw));
        cw_ready = 1'b1;
        tick();
        check("t4_after_release_valid", 32'(cw_valid), 0);
        check("t4_after_release_ready", 32'(msg_ready), 1);
        tick();
        check("t4_no_extra_valid", 32'(cw_valid), 0);

        // Reset on the third SHIFT cycle
        accept(15'h1000);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t5_rst_cw_valid", 32'(cw_valid), 0);
        check("t5_rst_codeword", 32'(codeword), 0);
        check("t5_rst_msg_ready", 32'(msg_ready), 1);
        reset = 1'b0;
        tick();
        accept(15'h1000);
        lat = 1;
        wait_valid(lat);
        check("t5_reencode_latency", 32'(lat), 6);
        check("t5_reencode", 32'(codeword), 32'h040032);
        tick();

`ifdef RS_ERR_INJECT_EN
        err_pos = 3'd5;
        err_val = 3'd4;
        accept(15'h0001);
        err_pos = 3'($urandom);
        err_val = 3'($urandom);
        lat = 1;
        wait_valid(lat);
        check("t6_inject", 32'(codeword), 32'h004073);
        tick();
`endif

        // Randomized messages against the reference model with random backpressure
        for (int k = 0; k < 30; k++) begin
            m = 15'($urandom);
            exp_cw = ref_cw(m);
`ifdef RS_ERR_INJECT_EN
            err_pos = (k % 3 == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            err_val = 3'($urandom);
            exp_cw = exp_cw ^ err_mask(int'(err_pos), int'(err_val));
`endif
            cw_ready = 1'b0;
            accept(m);
`ifdef RS_ERR_INJECT_EN
            err_pos = 3'($urandom);
            err_val = 3'($urandom);
`endif
            lat = 1;
            wait_valid(lat);
            check("rnd_latency", 32'(lat), 6);
            check("rnd_codeword", 32'(codeword), 32'(exp_cw));
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                tick();
                check("rnd_hold", 32'(codeword), 32'(exp_cw));
            end
            cw_ready = 1'b1;
            tick();
            check("rnd_released", 32'(cw_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
